// File: rtl/fofb_readout_sequencer.sv
// Sweeps the merged FOFB readout RAM once per FA cycle and streams each BPM's
// {Y, X} position with {present, address} sideband over an AXI-Stream master.
module fofb_readout_sequencer #(
  parameter int FOFB_INDEX_WIDTH = 9,
  parameter int BPM_COUNT        = 512
) (
  input  logic                        sysClk,
  input  logic                        sysResetN,
  input  logic                        readoutValid,
  input  logic                        readoutActive,
  output logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutAddress,
  input  logic [31:0]                 fofbDSPreadoutX,
  input  logic [31:0]                 fofbDSPreadoutY,
  input  logic                        fofbDSPreadoutPresent,
  output logic                        M_TVALID,
  input  logic                        M_TREADY,
  output logic [63:0]                 M_TDATA,
  output logic [FOFB_INDEX_WIDTH:0]   M_TUSER,
  output logic                        M_TLAST,
  output logic [FOFB_INDEX_WIDTH:0]   presentCount,
  output logic                        sweepDoneStrobe,
  output logic                        abortStrobe,
  output logic                        busy
);

  localparam logic [FOFB_INDEX_WIDTH-1:0] LAST_ADDRESS = FOFB_INDEX_WIDTH'(BPM_COUNT - 1);
  localparam logic [FOFB_INDEX_WIDTH-1:0] ADDRESS_STEP = FOFB_INDEX_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, EMIT} seqState_t;

  seqState_t                 state;
  logic                      readoutValidD;
  logic [FOFB_INDEX_WIDTH:0] runningCount;
  logic                      abortFlag;

  logic                      startEdge;
  logic                      abortNow;
  logic                      handshake;
  logic [FOFB_INDEX_WIDTH:0] countNext;

  assign startEdge = readoutValid & ~readoutValidD;
  assign abortNow  = abortFlag | readoutActive;
  assign handshake = M_TVALID & M_TREADY;
  assign countNext = runningCount + (FOFB_INDEX_WIDTH+1)'(M_TUSER[FOFB_INDEX_WIDTH]);
  assign busy      = (state != IDLE);

  // Each BPM takes FETCH (RAM latency), CAPTURE (register beat), EMIT (handshake),
  // so every address is held for at least three cycles.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      state                 <= IDLE;
      readoutValidD         <= 1'b0;
      fofbDSPreadoutAddress <= '0;
      runningCount          <= '0;
      abortFlag             <= 1'b0;
      M_TVALID              <= 1'b0;
      M_TDATA               <= '0;
      M_TUSER               <= '0;
      M_TLAST               <= 1'b0;
      presentCount          <= '0;
      sweepDoneStrobe       <= 1'b0;
      abortStrobe           <= 1'b0;
    end else begin
      readoutValidD   <= readoutValid;
      sweepDoneStrobe <= 1'b0;
      abortStrobe     <= 1'b0;
      if (state != IDLE && readoutActive) abortFlag <= 1'b1;

      case (state)
        IDLE: begin
          if (startEdge) begin
            fofbDSPreadoutAddress <= '0;
            runningCount          <= '0;
            abortFlag             <= 1'b0;
            state                 <= FETCH;
          end
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          M_TDATA  <= {fofbDSPreadoutY, fofbDSPreadoutX};
          M_TUSER  <= {fofbDSPreadoutPresent, fofbDSPreadoutAddress};
          M_TLAST  <= (fofbDSPreadoutAddress == LAST_ADDRESS) || abortNow;
          M_TVALID <= 1'b1;
          state    <= EMIT;
        end
        EMIT: begin
          // A late abort only retags the pending beat; the beat itself is never withdrawn.
          if (readoutActive && !handshake) M_TLAST <= 1'b1;
          if (handshake) begin
            runningCount <= countNext;
            M_TVALID     <= 1'b0;
            if (M_TLAST) begin
              fofbDSPreadoutAddress <= '0;
              abortFlag             <= 1'b0;
              state                 <= IDLE;
              if (abortNow) begin
                abortStrobe <= 1'b1;
              end else begin
                presentCount    <= countNext;
                sweepDoneStrobe <= 1'b1;
              end
            end else begin
              fofbDSPreadoutAddress <= fofbDSPreadoutAddress + ADDRESS_STEP;
              state                 <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fofb_readout_sequencer.sv
// Scoreboard bench: a 4-BPM instance for normal/backpressure/abort/re-trigger/reset
// sweeps and a 3-bit, 8-BPM instance for the full-range count.
module tb_fofb_readout_sequencer;

  logic sysClk    = 1'b0;
  logic sysResetN = 1'b0;
  always #5 sysClk = ~sysClk;

  logic        rvA = 1'b0, activeA = 1'b0, treadyA = 1'b1;
  logic [8:0]  addrA;
  logic [31:0] xA = '0, yA = '0;
  logic        presentA = 1'b0;
  logic        tvalidA, tlastA, doneA, abortA, busyA;
  logic [63:0] tdataA;
  logic [9:0]  tuserA, pcA;

  logic        rvB = 1'b0, activeB = 1'b0, treadyB = 1'b1;
  logic [2:0]  addrB;
  logic [31:0] xB = '0, yB = '0;
  logic        presentB = 1'b0;
  logic        tvalidB, tlastB, doneB, abortB, busyB;
  logic [63:0] tdataB;
  logic [3:0]  tuserB, pcB;

  logic [15:0] tagA = '0, tagB = '0;
  logic [7:0]  patA = '0, patB = '0;

  typedef struct packed {
    logic [63:0] data;
    logic [9:0]  user;
    logic        last;
  } beatT;

  beatT expA[$];
  beatT expB[$];

  int checks = 0, failures = 0;
  int doneCntA = 0, abortCntA = 0, doneCntB = 0, abortCntB = 0;
  int doneSnap = 0, abortSnap = 0;

  logic        holdValid = 1'b0;
  logic [63:0] holdData  = '0;
  logic [9:0]  holdUser  = '0;
  logic        holdLast  = 1'b0;

  fofb_readout_sequencer #(.FOFB_INDEX_WIDTH(9), .BPM_COUNT(4)) dutA (
    .sysClk(sysClk), .sysResetN(sysResetN), .readoutValid(rvA), .readoutActive(activeA),
    .fofbDSPreadoutAddress(addrA), .fofbDSPreadoutX(xA), .fofbDSPreadoutY(yA),
    .fofbDSPreadoutPresent(presentA), .M_TVALID(tvalidA), .M_TREADY(treadyA),
    .M_TDATA(tdataA), .M_TUSER(tuserA), .M_TLAST(tlastA), .presentCount(pcA),
    .sweepDoneStrobe(doneA), .abortStrobe(abortA), .busy(busyA)
  );

  fofb_readout_sequencer #(.FOFB_INDEX_WIDTH(3), .BPM_COUNT(8)) dutB (
    .sysClk(sysClk), .sysResetN(sysResetN), .readoutValid(rvB), .readoutActive(activeB),
    .fofbDSPreadoutAddress(addrB), .fofbDSPreadoutX(xB), .fofbDSPreadoutY(yB),
    .fofbDSPreadoutPresent(presentB), .M_TVALID(tvalidB), .M_TREADY(treadyB),
    .M_TDATA(tdataB), .M_TUSER(tuserB), .M_TLAST(tlastB), .presentCount(pcB),
    .sweepDoneStrobe(doneB), .abortStrobe(abortB), .busy(busyB)
  );

  // Upstream readout RAM: data and present flag arrive one cycle after the address.
  always @(posedge sysClk) begin
    xA       <= {tagA, 7'b0, addrA};
    yA       <= {8'h5A, addrA[7:0], tagA};
    presentA <= patA[addrA[2:0]];
    xB       <= {tagB, 13'b0, addrB};
    yB       <= {8'h5A, 5'b0, addrB, tagB};
    presentB <= patB[addrB];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBeat(input bit useB, input logic [63:0] d, input logic [9:0] u, input logic l);
    beatT e;
    if ((useB && expB.size() == 0) || (!useB && expA.size() == 0)) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got beat with user 0x%0h, expected no beat", useB ? "beatB" : "beatA", u);
    end else begin
      if (useB) e = expB.pop_front();
      else      e = expA.pop_front();
      checkOutput(useB ? "beatDataB" : "beatDataA", d, e.data);
      checkOutput(useB ? "beatUserB" : "beatUserA", 64'(u), 64'(e.user));
      checkOutput(useB ? "beatLastB" : "beatLastA", 64'(l), 64'(e.last));
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks beat stability while stalled.
  always @(negedge sysClk) begin
    if (!sysResetN) begin
      holdValid <= 1'b0;
    end else begin
      if (tvalidA && treadyA) checkBeat(1'b0, tdataA, tuserA, tlastA);
      if (tvalidA && !treadyA) begin
        if (holdValid) begin
          checkOutput("stallDataA", tdataA, holdData);
          checkOutput("stallUserA", 64'(tuserA), 64'(holdUser));
          checkOutput("stallLastA", 64'(tlastA), 64'(holdLast));
        end
        holdValid <= 1'b1;
        holdData  <= tdataA;
        holdUser  <= tuserA;
        holdLast  <= tlastA;
      end else begin
        holdValid <= 1'b0;
      end
      if (tvalidB && treadyB) checkBeat(1'b1, tdataB, {6'b0, tuserB}, tlastB);
    end
    if (doneA)  doneCntA  <= doneCntA + 1;
    if (abortA) abortCntA <= abortCntA + 1;
    if (doneB)  doneCntB  <= doneCntB + 1;
    if (abortB) abortCntB <= abortCntB + 1;
  end

  // Queues the expected beats (last beat at lastIdx) and then raises readoutValid.
  task automatic applyStimulus(input bit useB, input logic [15:0] tag, input logic [7:0] pat, input int lastIdx);
    beatT e;
    for (int i = 0; i <= lastIdx; i++) begin
      e.data = {8'h5A, 8'(i), tag, tag, 16'(i)};
      e.user = useB ? {6'b0, pat[i], 3'(i)} : {pat[i], 9'(i)};
      e.last = (i == lastIdx);
      if (useB) expB.push_back(e);
      else      expA.push_back(e);
    end
    if (useB) begin
      tagB = tag; patB = pat; rvB = 1'b0;
      doneSnap = doneCntB; abortSnap = abortCntB;
    end else begin
      tagA = tag; patA = pat; rvA = 1'b0;
      doneSnap = doneCntA; abortSnap = abortCntA;
    end
    @(posedge sysClk); #1;
    if (useB) rvB = 1'b1;
    else      rvA = 1'b1;
  endtask

  task automatic waitStrobe(input bit useB, input bit wantAbort, input int budget, input int expCycles, input string name);
    int cycles = 0;
    bit seen = 1'b0;
    while (!seen && cycles < budget) begin
      @(posedge sysClk); #1;
      cycles++;
      seen = useB ? (wantAbort ? abortB : doneB) : (wantAbort ? abortA : doneA);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got no strobe in %0d cycles, expected one", name, budget);
    end else if (expCycles > 0) begin
      checkOutput(name, 64'(cycles), 64'(expCycles));
    end
  endtask

  task automatic waitAddrA(input logic [8:0] target, input int budget);
    int cycles = 0;
    while (addrA !== target && cycles < budget) begin
      @(posedge sysClk); #1;
      cycles++;
    end
    checkOutput("reachAddrA", 64'(addrA), 64'(target));
  endtask

  task automatic waitValidA(input int budget);
    int cycles = 0;
    while (tvalidA !== 1'b1 && cycles < budget) begin
      @(posedge sysClk); #1;
      cycles++;
    end
    checkOutput("reachValidA", 64'(tvalidA), 64'd1);
  endtask

  task automatic checkSweepEnd(input bit useB, input int expPc, input int expDone, input int expAbort);
    checkOutput(useB ? "presentCountB" : "presentCountA", useB ? 64'(pcB) : 64'(pcA), 64'(expPc));
    checkOutput(useB ? "endAddrB" : "endAddrA", useB ? 64'(addrB) : 64'(addrA), 64'd0);
    checkOutput(useB ? "endBusyB" : "endBusyA", useB ? 64'(busyB) : 64'(busyA), 64'd0);
    repeat (2) @(posedge sysClk);
    #1;
    checkOutput(useB ? "doneCountB" : "doneCountA",
                64'((useB ? doneCntB : doneCntA) - doneSnap), 64'(expDone));
    checkOutput(useB ? "abortCountB" : "abortCountA",
                64'((useB ? abortCntB : abortCntA) - abortSnap), 64'(expAbort));
    checkOutput(useB ? "queueLeftB" : "queueLeftA",
                64'(useB ? expB.size() : expA.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge sysClk);
    #1;
    checkOutput("rstValidA", 64'(tvalidA), 64'd0);
    checkOutput("rstLastA",  64'(tlastA),  64'd0);
    checkOutput("rstDataA",  tdataA,       64'd0);
    checkOutput("rstUserA",  64'(tuserA),  64'd0);
    checkOutput("rstCountA", 64'(pcA),     64'd0);
    checkOutput("rstAddrA",  64'(addrA),   64'd0);
    checkOutput("rstBusyA",  64'(busyA),   64'd0);
    checkOutput("rstDoneA",  64'(doneA),   64'd0);
    checkOutput("rstAbortA", 64'(abortA),  64'd0);
    checkOutput("rstValidB", 64'(tvalidB), 64'd0);
    checkOutput("rstCountB", 64'(pcB),     64'd0);
    sysResetN = 1'b1;
    @(posedge sysClk); #1;

    $display("[TB] normal sweep, present 1,0,1,1");
    applyStimulus(1'b0, 16'h1111, 8'b0000_1101, 3);
    waitStrobe(1'b0, 1'b0, 60, 13, "sweepCyclesA");
    checkSweepEnd(1'b0, 3, 1, 0);

    $display("[TB] backpressure on beat 1");
    applyStimulus(1'b0, 16'h2222, 8'b0000_0110, 3);
    waitAddrA(9'd1, 20);
    treadyA = 1'b0;
    waitValidA(20);
    repeat (5) @(posedge sysClk);
    #1;
    checkOutput("stallAddrA",  64'(addrA),   64'd1);
    checkOutput("stallValidA", 64'(tvalidA), 64'd1);
    treadyA = 1'b1;
    waitStrobe(1'b0, 1'b0, 60, 0, "backpressureDoneA");
    checkSweepEnd(1'b0, 2, 1, 0);

    $display("[TB] abort during fetch of address 2");
    applyStimulus(1'b0, 16'h3333, 8'b0000_1111, 2);
    waitAddrA(9'd2, 20);
    activeA = 1'b1;
    @(posedge sysClk); #1;
    activeA = 1'b0;
    waitStrobe(1'b0, 1'b1, 60, 0, "abortStrobeA");
    checkSweepEnd(1'b0, 2, 0, 1);

    $display("[TB] re-trigger mid-sweep");
    applyStimulus(1'b0, 16'h4444, 8'b0000_1000, 3);
    waitAddrA(9'd1, 20);
    rvA = 1'b0;
    @(posedge sysClk); #1;
    rvA = 1'b1;
    waitStrobe(1'b0, 1'b0, 60, 0, "retriggerDoneA");
    checkSweepEnd(1'b0, 1, 1, 0);
    repeat (12) @(posedge sysClk);
    #1;
    checkOutput("noRetriggerValidA", 64'(tvalidA), 64'd0);
    checkOutput("noRetriggerBusyA",  64'(busyA),   64'd0);

    $display("[TB] reset during emit");
    treadyA = 1'b0;
    applyStimulus(1'b0, 16'h5555, 8'b0000_0001, 3);
    waitValidA(20);
    #2 sysResetN = 1'b0;
    #1;
    checkOutput("midResetValidA", 64'(tvalidA), 64'd0);
    checkOutput("midResetAddrA",  64'(addrA),   64'd0);
    checkOutput("midResetDataA",  tdataA,       64'd0);
    checkOutput("midResetBusyA",  64'(busyA),   64'd0);
    expA.delete();
    rvA = 1'b0;
    repeat (2) @(posedge sysClk);
    #1;
    sysResetN = 1'b1;
    treadyA   = 1'b1;
    repeat (10) @(posedge sysClk);
    #1;
    checkOutput("postResetDoneA",  64'(doneCntA - doneSnap),   64'd0);
    checkOutput("postResetAbortA", 64'(abortCntA - abortSnap), 64'd0);
    checkOutput("postResetValidA", 64'(tvalidA), 64'd0);

    $display("[TB] full range, 8 BPMs all present");
    applyStimulus(1'b1, 16'h6666, 8'hFF, 7);
    waitStrobe(1'b1, 1'b0, 120, 25, "sweepCyclesB");
    checkSweepEnd(1'b1, 8, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
